// File: rtl/recv_partition.sv
// Receive stage of a quickselect pass. It pops one packet header, then partitions
// the packet's pixels around the pivot into a local buffer and reports the surviving side.
module recv_partition #(
  parameter int BUFF_SIZE     = 32,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    recv_px_data,
  input  logic                     recv_px_empty,
  output logic                     recv_px_rd,
  input  logic [DATA_WIDTH-1:0]    recv_pivot_data,
  input  logic                     recv_pivot_empty,
  output logic                     recv_pivot_rd,
  input  logic [BUFF_SIZE_BIT-1:0] recv_buff_size_data,
  input  logic                     recv_buff_size_empty,
  output logic                     recv_buff_size_rd,
  input  logic [BUFF_SIZE_BIT-1:0] recv_median_pos_data,
  input  logic                     recv_median_pos_empty,
  output logic                     recv_median_pos_rd,
  input  logic [DATA_WIDTH-1:0]    recv_second_median_value_data,
  input  logic                     recv_second_median_value_empty,
  output logic                     recv_second_median_value_rd,
  output logic                     buff_wr,
  output logic [BUFF_SIZE_BIT-1:0] buff_addr,
  output logic [DATA_WIDTH-1:0]    buff_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     median_found,
  output logic [DATA_WIDTH-1:0]    median_value,
  output logic [BUFF_SIZE_BIT-1:0] part_base,
  output logic [BUFF_SIZE_BIT-1:0] part_size,
  output logic [BUFF_SIZE_BIT-1:0] part_median_pos,
  output logic [DATA_WIDTH-1:0]    second_median_value
);

  typedef enum logic [1:0] {IDLE, RECV, DECIDE, DONE} state_t;

  localparam logic [BUFF_SIZE_BIT-1:0] ONE      = BUFF_SIZE_BIT'(1);
  localparam logic [BUFF_SIZE_BIT-1:0] ZERO     = '0;
  localparam logic [BUFF_SIZE_BIT-1:0] MAX_SIZE = BUFF_SIZE_BIT'(BUFF_SIZE);

  state_t r_state, w_state_next;

  logic [DATA_WIDTH-1:0]    r_pivot, r_second;
  logic [BUFF_SIZE_BIT-1:0] r_n, r_p;
  logic [BUFF_SIZE_BIT-1:0] r_lt_cnt, r_eq_cnt, r_rx_cnt, r_lo_ptr, r_hi_ptr;

  logic                     r_error, r_median_found;
  logic [DATA_WIDTH-1:0]    r_median_value, r_second_out;
  logic [BUFF_SIZE_BIT-1:0] r_part_base, r_part_size, r_part_median_pos;

  logic                     w_hdr_ready, w_hdr_pop, w_hdr_invalid, w_px_pop;
  logic                     w_lt, w_gt, w_last;
  logic [BUFF_SIZE_BIT-1:0] w_lt_eq;

  assign w_hdr_ready = ~recv_pivot_empty & ~recv_buff_size_empty &
                       ~recv_median_pos_empty & ~recv_second_median_value_empty;
  // Strobes are gated by rst_n so they read 0 while reset is held, whatever the FIFOs show.
  assign w_hdr_pop     = rst_n & (r_state == IDLE) & w_hdr_ready;
  assign w_px_pop      = rst_n & (r_state == RECV) & ~recv_px_empty;
  assign w_hdr_invalid = (recv_buff_size_data == ZERO) || (recv_buff_size_data > MAX_SIZE) ||
                         (recv_median_pos_data >= recv_buff_size_data);
  assign w_lt    = recv_px_data < r_pivot;
  assign w_gt    = recv_px_data > r_pivot;
  assign w_last  = (r_rx_cnt == r_n - ONE);
  assign w_lt_eq = r_lt_cnt + r_eq_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    recv_px_rd   = 1'b0;
    buff_wr      = 1'b0;
    buff_addr    = ZERO;
    buff_data    = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        busy = w_hdr_pop;
        if (w_hdr_pop) w_state_next = w_hdr_invalid ? DONE : RECV;
      end
      RECV: begin
        busy       = 1'b1;
        recv_px_rd = w_px_pop;
        if (w_px_pop) begin
          buff_wr   = w_lt | w_gt;
          buff_addr = w_gt ? r_hi_ptr : r_lo_ptr;
          buff_data = recv_px_data;
          if (w_last) w_state_next = DECIDE;
        end
      end
      DECIDE: begin
        busy         = 1'b1;
        w_state_next = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign recv_pivot_rd               = w_hdr_pop;
  assign recv_buff_size_rd           = w_hdr_pop;
  assign recv_median_pos_rd          = w_hdr_pop;
  assign recv_second_median_value_rd = w_hdr_pop;

  // Header capture and partition bookkeeping: smaller pixels fill upward from 0,
  // larger pixels fill downward from N-1, equal pixels are only counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pivot  <= '0;
      r_second <= '0;
      r_n      <= ZERO;
      r_p      <= ZERO;
      r_lt_cnt <= ZERO;
      r_eq_cnt <= ZERO;
      r_rx_cnt <= ZERO;
      r_lo_ptr <= ZERO;
      r_hi_ptr <= ZERO;
    end else if (w_hdr_pop) begin
      r_pivot  <= recv_pivot_data;
      r_second <= recv_second_median_value_data;
      r_n      <= recv_buff_size_data;
      r_p      <= recv_median_pos_data;
      r_lt_cnt <= ZERO;
      r_eq_cnt <= ZERO;
      r_rx_cnt <= ZERO;
      r_lo_ptr <= ZERO;
      r_hi_ptr <= recv_buff_size_data - ONE;
    end else if (w_px_pop) begin
      r_rx_cnt <= r_rx_cnt + ONE;
      if (w_lt) begin
        r_lo_ptr <= r_lo_ptr + ONE;
        r_lt_cnt <= r_lt_cnt + ONE;
      end else if (w_gt) begin
        r_hi_ptr <= r_hi_ptr - ONE;
      end else begin
        r_eq_cnt <= r_eq_cnt + ONE;
      end
    end
  end

  // Result registers change only on entry to DONE and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error           <= 1'b0;
      r_median_found    <= 1'b0;
      r_median_value    <= '0;
      r_part_base       <= ZERO;
      r_part_size       <= ZERO;
      r_part_median_pos <= ZERO;
      r_second_out      <= '0;
    end else if (w_hdr_pop && w_hdr_invalid) begin
      r_error           <= 1'b1;
      r_median_found    <= 1'b0;
      r_median_value    <= '0;
      r_part_base       <= ZERO;
      r_part_size       <= ZERO;
      r_part_median_pos <= ZERO;
      r_second_out      <= recv_second_median_value_data;
    end else if (r_state == DECIDE) begin
      r_error           <= 1'b0;
      r_median_found    <= 1'b0;
      r_median_value    <= '0;
      r_part_base       <= ZERO;
      r_part_size       <= ZERO;
      r_part_median_pos <= ZERO;
      r_second_out      <= r_second;
      if (r_p < r_lt_cnt) begin
        r_part_size       <= r_lt_cnt;
        r_part_median_pos <= r_p;
      end else if (r_p < w_lt_eq) begin
        r_median_found <= 1'b1;
        r_median_value <= r_pivot;
      end else begin
        r_part_base       <= w_lt_eq;
        r_part_size       <= r_n - w_lt_eq;
        r_part_median_pos <= r_p - w_lt_eq;
      end
    end
  end

  assign error               = r_error;
  assign median_found        = r_median_found;
  assign median_value        = r_median_value;
  assign part_base           = r_part_base;
  assign part_size           = r_part_size;
  assign part_median_pos     = r_part_median_pos;
  assign second_median_value = r_second_out;

endmodule

// File: tb/tb_recv_partition.sv
// Bench for recv_partition: FIFO models feed directed and random packets; results are
// checked against a sort-based reference of the partition rules.
module tb_recv_partition;
  localparam int BS  = 32;
  localparam int BSB = 6;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]  px_mem [0:255];
  logic [7:0]     px_wr_i = '0, px_rd_i = '0;
  logic           px_stall = 1'b0;
  logic [DW-1:0]  h_piv [0:15];
  logic [DW-1:0]  h_sec [0:15];
  logic [BSB-1:0] h_n [0:15];
  logic [BSB-1:0] h_p [0:15];
  logic [3:0]     h_wr_i = '0, h_rd_i = '0;

  logic recv_px_rd, recv_pivot_rd, recv_buff_size_rd, recv_median_pos_rd, recv_second_median_value_rd;
  logic buff_wr, busy, done, error, median_found;
  logic [BSB-1:0] buff_addr, part_base, part_size, part_median_pos;
  logic [DW-1:0]  buff_data, median_value, second_median_value;
  logic hdr_empty;

  assign hdr_empty = (h_rd_i == h_wr_i);

  recv_partition dut (
    .clk(clk), .rst_n(rst_n),
    .recv_px_data(px_mem[px_rd_i]), .recv_px_empty((px_rd_i == px_wr_i) || px_stall), .recv_px_rd(recv_px_rd),
    .recv_pivot_data(h_piv[h_rd_i]), .recv_pivot_empty(hdr_empty), .recv_pivot_rd(recv_pivot_rd),
    .recv_buff_size_data(h_n[h_rd_i]), .recv_buff_size_empty(hdr_empty), .recv_buff_size_rd(recv_buff_size_rd),
    .recv_median_pos_data(h_p[h_rd_i]), .recv_median_pos_empty(hdr_empty), .recv_median_pos_rd(recv_median_pos_rd),
    .recv_second_median_value_data(h_sec[h_rd_i]), .recv_second_median_value_empty(hdr_empty),
    .recv_second_median_value_rd(recv_second_median_value_rd),
    .buff_wr(buff_wr), .buff_addr(buff_addr), .buff_data(buff_data),
    .busy(busy), .done(done), .error(error), .median_found(median_found), .median_value(median_value),
    .part_base(part_base), .part_size(part_size), .part_median_pos(part_median_pos),
    .second_median_value(second_median_value)
  );

  int tests = 0, fails = 0;
  int cyc = 0;
  int hdr_cyc, first_pop_cyc, last_pop_cyc, done_cyc, done_cnt;
  int pkt_pops, wr_cnt, wr_no_pop, pop_empty, busy_gap, hdr_split, rst_bad;
  int stall_after, stall_len, stall_cnt;
  int s_busy, s_done;
  int o_err, o_found, o_mval, o_base, o_size, o_pos, o_sec;
  int tb_buf [0:63];
  int pix_q[$];
  int c_piv, c_n, c_p, c_sec;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample everything at the falling edge, then advance the FIFO models just after the rising edge.
  task automatic tick();
    logic px_pop, hdr_pop;
    @(negedge clk);
    cyc++;
    px_pop  = recv_px_rd;
    hdr_pop = recv_pivot_rd;
    s_busy  = int'(busy);
    s_done  = int'(done);
    if (!rst_n && (|{recv_px_rd, recv_pivot_rd, recv_buff_size_rd, recv_median_pos_rd,
                     recv_second_median_value_rd, buff_wr, buff_addr, buff_data, busy, done, error,
                     median_found, median_value, part_base, part_size, part_median_pos,
                     second_median_value}))
      rst_bad++;
    if ({recv_pivot_rd, recv_buff_size_rd, recv_median_pos_rd, recv_second_median_value_rd} != 4'b0000 &&
        {recv_pivot_rd, recv_buff_size_rd, recv_median_pos_rd, recv_second_median_value_rd} != 4'b1111)
      hdr_split++;
    if (hdr_pop) hdr_cyc = cyc;
    if (buff_wr) begin
      wr_cnt++;
      tb_buf[buff_addr] = int'(buff_data);
      if (!recv_px_rd) wr_no_pop++;
    end
    if (recv_px_rd) begin
      pkt_pops++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      if ((px_rd_i == px_wr_i) || px_stall) pop_empty++;
    end
    if (rst_n && hdr_cyc >= 0 && done_cyc < 0 && !busy) busy_gap++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      o_err = int'(error); o_found = int'(median_found); o_mval = int'(median_value);
      o_base = int'(part_base); o_size = int'(part_size); o_pos = int'(part_median_pos);
      o_sec = int'(second_median_value);
    end
    @(posedge clk);
    #1;
    if (px_pop && px_rd_i != px_wr_i) px_rd_i = px_rd_i + 8'd1;
    if (hdr_pop && !hdr_empty) h_rd_i = h_rd_i + 4'd1;
    if (stall_len > 0 && pkt_pops == stall_after && stall_cnt < stall_len) begin
      px_stall = 1'b1;
      stall_cnt++;
    end else begin
      px_stall = 1'b0;
    end
  endtask

  task automatic push_pkt(input int piv, input int n, input int p, input int sec, input int st_after, input int st_len);
    c_piv = piv; c_n = n; c_p = p; c_sec = sec;
    hdr_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1; done_cyc = -1; done_cnt = 0;
    pkt_pops = 0; wr_cnt = 0; wr_no_pop = 0; pop_empty = 0; busy_gap = 0; hdr_split = 0;
    stall_after = st_after; stall_len = st_len; stall_cnt = 0;
    for (int i = 0; i < 64; i++) tb_buf[i] = -1;
    foreach (pix_q[i]) begin
      px_mem[px_wr_i] = DW'(pix_q[i]);
      px_wr_i = px_wr_i + 8'd1;
    end
    h_piv[h_wr_i] = DW'(piv); h_n[h_wr_i] = BSB'(n); h_p[h_wr_i] = BSB'(p); h_sec[h_wr_i] = DW'(sec);
    h_wr_i = h_wr_i + 4'd1;
  endtask

  // Reference: rank the packet by sorting, then read the rules off the sorted order.
  task automatic finish_pkt(input string name);
    int lt, eq, gt, mism, e_found, e_base, e_size, e_pos, v;
    int lo[$], hi[$], s[$];
    bit invalid;
    for (int k = 0; k < 400 && done_cnt == 0; k++) tick();
    check({name, ":done_seen"}, done_cnt, 1);
    tick();
    check({name, ":done_one_cycle"}, done_cnt + s_done, 1);
    check({name, ":busy_after_done"}, s_busy, 0);
    check({name, ":busy_gap"}, busy_gap, 0);
    check({name, ":hdr_rd_together"}, hdr_split, 0);
    check({name, ":second_value"}, o_sec, c_sec);
    invalid = (c_n == 0) || (c_n > BS) || (c_p >= c_n);
    if (invalid) begin
      check({name, ":error"}, o_err, 1);
      check({name, ":found"}, o_found, 0);
      check({name, ":size"}, o_size, 0);
      check({name, ":done_latency"}, done_cyc - hdr_cyc, 1);
      check({name, ":pops"}, pkt_pops, 0);
      check({name, ":writes"}, wr_cnt, 0);
      $display("[TB] pkt %s piv=%0d n=%0d p=%0d -> err=%0d", name, c_piv, c_n, c_p, o_err);
      return;
    end
    lt = 0; eq = 0; gt = 0;
    foreach (pix_q[i]) begin
      if (pix_q[i] < c_piv) begin lt++; lo.push_back(pix_q[i]); end
      else if (pix_q[i] > c_piv) begin gt++; hi.push_back(pix_q[i]); end
      else eq++;
    end
    s = pix_q;
    s.sort();
    v = s[c_p];
    e_found = (v == c_piv) ? 1 : 0;
    e_base = 0; e_size = 0; e_pos = 0;
    if (v < c_piv) begin e_size = lt; e_pos = c_p; end
    else if (v > c_piv) begin e_base = lt + eq; e_size = gt; e_pos = c_p - lt - eq; end
    mism = 0;
    foreach (lo[i]) if (tb_buf[i] != lo[i]) mism++;
    foreach (hi[j]) if (tb_buf[c_n - 1 - j] != hi[j]) mism++;
    check({name, ":error"}, o_err, 0);
    check({name, ":found"}, o_found, e_found);
    if (e_found) check({name, ":median_value"}, o_mval, c_piv);
    check({name, ":size"}, o_size, e_size);
    if (e_size != 0) begin
      check({name, ":base"}, o_base, e_base);
      check({name, ":pos"}, o_pos, e_pos);
    end
    check({name, ":buffer"}, mism, 0);
    check({name, ":writes"}, wr_cnt, lt + gt);
    check({name, ":pops"}, pkt_pops, c_n);
    check({name, ":wr_without_pop"}, wr_no_pop + pop_empty, 0);
    check({name, ":first_pop_after_hdr"}, int'(first_pop_cyc > hdr_cyc), 1);
    check({name, ":done_latency"}, done_cyc - last_pop_cyc, 2);
    $display("[TB] pkt %s piv=%0d n=%0d p=%0d -> err=%0d found=%0d mval=%0d base=%0d size=%0d pos=%0d",
             name, c_piv, c_n, c_p, o_err, o_found, o_mval, o_base, o_size, o_pos);
  endtask

  initial begin
    int n, piv;
    rst_bad = 0;
    hdr_cyc = -1; done_cyc = -1;
    for (int i = 0; i < 256; i++) px_mem[i] = '0;
    for (int i = 0; i < 16; i++) begin h_piv[i] = '0; h_n[i] = '0; h_p[i] = '0; h_sec[i] = '0; end
    stall_len = 0;

    // Reset with a header waiting: strobes must stay low until release.
    pix_q = {9, 1, 5, 7, 3};
    push_pkt(5, 5, 2, 77, 0, 0);
    repeat (3) tick();
    check("reset:outputs_zero", rst_bad, 0);
    rst_n = 1'b1;
    finish_pkt("plan1");

    pix_q = {2, 20, 4, 30};
    push_pkt(10, 4, 1, 3, 0, 0);
    finish_pkt("plan2_low");

    pix_q = {2, 20, 10, 30};
    push_pkt(10, 4, 3, 200, 0, 0);
    finish_pkt("plan3_high");

    pix_q = {1, 2, 3};
    push_pkt(7, 0, 0, 11, 0, 0);
    finish_pkt("inv_n0");
    check("inv_n0:px_untouched", int'(px_wr_i - px_rd_i), 3);
    px_rd_i = px_wr_i;

    pix_q = {4, 4, 4, 4};
    push_pkt(7, 4, 4, 12, 0, 0);
    finish_pkt("inv_p_eq_n");
    check("inv_p_eq_n:px_untouched", int'(px_wr_i - px_rd_i), 4);
    px_rd_i = px_wr_i;

    pix_q = {};
    push_pkt(7, 40, 1, 13, 0, 0);
    finish_pkt("inv_n_big");

    pix_q = {6, 12, 9, 3};
    push_pkt(8, 4, 2, 5, 0, 0);
    finish_pkt("nostall");
    pix_q = {6, 12, 9, 3};
    push_pkt(8, 4, 2, 5, 2, 3);
    finish_pkt("stall");
    check("stall:stall_cycles", stall_cnt, 3);

    // Abort a packet mid-stream; the stale pixels are flushed before the next packet.
    pix_q = {9, 1, 5, 7, 3};
    push_pkt(5, 5, 2, 1, 0, 0);
    for (int k = 0; k < 50 && pkt_pops < 2; k++) tick();
    check("abort:pops_before_reset", pkt_pops, 2);
    rst_n = 1'b0;
    px_rd_i = px_wr_i;
    rst_bad = 0;
    pix_q = {30, 10, 20, 10, 40, 5};
    push_pkt(20, 6, 4, 99, 0, 0);
    repeat (3) tick();
    check("abort:outputs_zero", rst_bad, 0);
    rst_n = 1'b1;
    finish_pkt("after_abort");

    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(1, BS);
      pix_q = {};
      for (int i = 0; i < n; i++) pix_q.push_back($urandom_range(0, 15));
      piv = ($urandom_range(0, 1) == 1) ? pix_q[$urandom_range(0, n - 1)] : $urandom_range(0, 15);
      push_pkt(piv, n, $urandom_range(0, n - 1), $urandom_range(0, 255),
               $urandom_range(0, n - 1), $urandom_range(0, 2));
      finish_pkt($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/recv_partition.md
# recv_partition

Downstream consumer of the accelerator's send stage. Pops one packet header (pivot, buffer size, median position, second median value) from four control FIFOs. Then pops exactly buffer-size pixels from the pixel FIFO and partitions them around the pivot into a local pixel buffer. Finally reports either the median value or the surviving partition (base, size, new median position) for the next quickselect pass.

## Interface
- BUFF_SIZE, 32, maximum pixels per packet
- BUFF_SIZE_BIT, $clog2(BUFF_SIZE)+1, width of size/position/count/address fields
- DATA_WIDTH, 8, pixel width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- recv_px_data  in  DATA_WIDTH  head of pixel FIFO (first-word-fall-through)
- recv_px_empty  in  1  pixel FIFO empty
- recv_px_rd  out  1  pop pixel FIFO
- recv_pivot_data / recv_pivot_empty / recv_pivot_rd  in/in/out  DATA_WIDTH/1/1  pivot FIFO
- recv_buff_size_data / recv_buff_size_empty / recv_buff_size_rd  in/in/out  BUFF_SIZE_BIT/1/1  packet size FIFO
- recv_median_pos_data / recv_median_pos_empty / recv_median_pos_rd  in/in/out  BUFF_SIZE_BIT/1/1  target rank FIFO
- recv_second_median_value_data / _empty / _rd  in/in/out  DATA_WIDTH/1/1  second median FIFO
- buff_wr  out  1  local buffer write strobe
- buff_addr  out  BUFF_SIZE_BIT  local buffer write address
- buff_data  out  DATA_WIDTH  local buffer write data
- busy  out  1  high from header pop until DONE
- done  out  1  one-cycle result strobe
- error  out  1  header invalid (valid with done)
- median_found  out  1  median equals pivot (valid with done)
- median_value  out  DATA_WIDTH  pivot when median_found
- part_base  out  BUFF_SIZE_BIT  first buffer address of kept partition
- part_size  out  BUFF_SIZE_BIT  pixels in kept partition
- part_median_pos  out  BUFF_SIZE_BIT  rank inside kept partition
- second_median_value  out  DATA_WIDTH  header value forwarded unchanged

## Operation
- States: IDLE, RECV, DECIDE, DONE.
- IDLE: when all four control FIFOs are non-empty, pulse all four rd together.
- In that same cycle, latch pivot, size N, pos P and second value; assert busy.
- Invalid header: N==0, N>BUFF_SIZE or P>=N. No pixels read; go to DONE with error=1, median_found=0, part_size=0.
- Valid header: go to RECV and clear lt_cnt, eq_cnt, rx_cnt and lo_ptr. Set hi_ptr=N-1.
- RECV: recv_px_rd = ~recv_px_empty (combinational). Per popped pixel x:
  - x<pivot: buff_wr=1, buff_addr=lo_ptr, then lo_ptr++, lt_cnt++.
  - x>pivot: buff_wr=1, buff_addr=hi_ptr, then hi_ptr--.
  - x==pivot: no write, eq_cnt++.
  - buff_data=x in every case; rx_cnt++.
- The pop with rx_cnt==N-1 is the last one; go to DECIDE. No extra pixel is ever popped.
- DECIDE (one cycle), comparisons unsigned, at BUFF_SIZE_BIT width:
  - P<lt_cnt: part_base=0, part_size=lt_cnt, part_median_pos=P.
  - P<lt_cnt+eq_cnt: median_found=1, median_value=pivot, part_size=0.
  - Otherwise, with G = N-lt_cnt-eq_cnt: part_base=lt_cnt+eq_cnt, part_size=G, part_median_pos=P-lt_cnt-eq_cnt.
- DONE: done=1 for one cycle; busy drops at the end of this cycle; go to IDLE.
- No header pop occurs in RECV, DECIDE or DONE.
- Result outputs are registered and hold until the next DONE.

## Timing
- Reset: state IDLE. Every output is 0, including the combinational rd/wr strobes, busy, done, error and all result fields.
- Reset mid-packet: the partial packet is abandoned. FIFO contents are not touched.
- Header pop at cycle T. Pixels are popped at rate 1/cycle, from T+1 at the earliest, stalling while recv_px_empty=1.
- Last pixel at cycle L: DECIDE at L+1, done at L+2, next header pop at L+3 at the earliest.
- Invalid header at T: done at T+1.
- Pixel FIFO going empty mid-packet: RECV stalls indefinitely with no timeout. Counters and pointers hold.
- buff_wr is asserted only in cycles where recv_px_rd=1.
- Partitions never overlap: at the end of RECV, lo_ptr == hi_ptr+1-eq_cnt.

## Test plan
- Header pivot=5, N=5, P=2; pixels 9,1,5,7,3 -> writes addr0=1, addr4=9, addr3=7, addr1=3. Then done with median_found=1, median_value=5, error=0.
- Pivot=10, N=4, P=1; pixels 2,20,4,30 -> part_base=0, part_size=2, part_median_pos=1, median_found=0.
- Pivot=10, N=4, P=3; pixels 2,20,10,30 -> part_base=2, part_size=2, part_median_pos=1. Writes at addr3=20, addr2=30.
- Header N=0 and, separately, N=4 with P=4 -> done one cycle after the header pop with error=1. recv_px_rd never asserted; pixel FIFO untouched.
- Pixel FIFO empty for 3 cycles after the 2nd of 4 pixels -> no pops or writes while empty. Result identical to the no-stall run. done exactly 2 cycles after the last pop.
- rst_n low after 2 of 5 pixels, then a new header -> all outputs 0 during reset. The new packet's result is independent of the aborted packet.
